row_mem_rd_ctrlr: RTL and testbench
===================================

ROW_MEM_RD_CTRLR -- requirements
Module: row_mem_rd_ctrlr

Interface
REQ-001 SHALL have parameter INPUT_BW, default 8, data width of row-memory entries (for bench reference only; no data path in this block).
REQ-002 SHALL have parameter IA_ROW_MEM_ADDR, default 6, IA row-memory address width.
REQ-003 SHALL have parameter WEIGHT_ROW_MEM_ADDR, default 7, weight row-memory address width.
REQ-004 SHALL have parameter NUM_IA_ROW_MEM, default 96, number of IA row memories.
REQ-005 SHALL have parameter NUM_WEIGHT_ROW_MEM, default 3, number of weight row memories.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a read sweep.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse, coincident with done, on illegal configuration.
REQ-011 SHALL have ports OC [5:0], IMG_W [5:0], K [2:0]  input  configuration (output channels, output width, kernel size).
REQ-012 SHALL have port which_ia_row_mem_activate  input  NUM_IA_ROW_MEM  mask of loaded IA row memories.
REQ-013 SHALL have port pe_ready  input  1  downstream PE array accepts data this cycle.
REQ-014 SHALL have ports ia_rd_en  output  NUM_IA_ROW_MEM and ia_rd_addr  output  IA_ROW_MEM_ADDR  broadcast IA read.
REQ-015 SHALL have ports weight_rd_en  output  NUM_WEIGHT_ROW_MEM and weight_rd_addr  output  WEIGHT_ROW_MEM_ADDR  weight read.
REQ-016 SHALL have ports rd_valid, kx_last, rd_last  output  1 each  flags aligned with read data returned from the memories.

Function
REQ-017 SHALL latch OC, IMG_W, K and which_ia_row_mem_activate on the cycle start is accepted; later changes SHALL be ignored until the next start.
REQ-018 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-019 SHALL implement states IDLE, READ, DRAIN, DONE; IDLE->READ on legal start, IDLE->DONE on illegal start, READ->DRAIN after the final read issues, DRAIN->DONE after one cycle, DONE->IDLE unconditionally.
REQ-020 SHALL treat as illegal: K not in {1,2,3}, OC==0, IMG_W==0, IMG_W+K-1>64, or OC*K>128; cfg_err SHALL pulse in DONE, and no read SHALL issue.
REQ-021 SHALL sweep nested counters oc (outer, 0..OC-1), x (0..IMG_W-1), kx (inner, 0..K-1), advancing one step per cycle in which a read issues.
REQ-022 SHALL issue a read in READ only when pe_ready==1; when pe_ready==0, all rd_en SHALL be 0 and the counters SHALL hold.
REQ-023 SHALL drive, on an issued read: ia_rd_addr = x+kx; ia_rd_en = latched activate mask; weight_rd_addr = oc*K+kx; weight_rd_en bits [K-1:0] = 1, others 0.
REQ-024 SHALL drive all rd_en to 0 outside issued-read cycles.
REQ-025 SHALL compute address arithmetic at 8 bits internally and truncate to port widths; legality checks (REQ-020) guarantee no truncation loss.
REQ-026 SHALL register read requests (rd_en and addresses as flops), and SHALL assert rd_valid exactly 1 cycle after each cycle with nonzero rd_en, matching the 1-cycle memory read latency.
REQ-027 SHALL assert kx_last with rd_valid when the originating read had kx==K-1, and rd_last when it was the final read (oc==OC-1, x==IMG_W-1, kx==K-1).
REQ-028 SHALL issue exactly OC*IMG_W*K reads per legal sweep; done SHALL assert the cycle after rd_last.

Reset
REQ-029 SHALL, when resetn==0 at a clock edge, go to IDLE and clear done, cfg_err, ia_rd_en, ia_rd_addr, weight_rd_en, weight_rd_addr, rd_valid, kx_last, rd_last, all counters and latched configuration to 0.
REQ-030 SHALL abandon any sweep on reset mid-operation with no done pulse; a subsequent start SHALL begin a fresh sweep from oc=x=kx=0.

Verification
REQ-031 K=3, OC=1, IMG_W=2, pe_ready=1 -> 6 reads, ia_rd_addr 0,1,2,1,2,3; weight_rd_addr 0,1,2,0,1,2; weight_rd_en=3'b111; kx_last on reads 3 and 6; rd_last on 6th valid; done next cycle.
REQ-032 K=1, OC=2, IMG_W=3 -> weight_rd_en=3'b001; weight_rd_addr 0,0,0,1,1,1; ia_rd_addr 0,1,2,0,1,2; 6 rd_valid pulses.
REQ-033 K=2, OC=1, IMG_W=2, pe_ready low every other cycle -> no rd_en during low cycles, addresses unchanged, total 4 reads, sequence identical to stall-free run.
REQ-034 K=4 (or OC=0, or IMG_W=63 with K=3) -> no rd_en ever, done and cfg_err pulse together 1 cycle after start.
REQ-035 resetn low for one cycle during READ at read 3 -> all outputs 0 next cycle, no done; new start reproduces full sequence from address 0.
REQ-036 start asserted during READ, and activate mask changed mid-sweep -> ignored; ia_rd_en equals mask latched at original start throughout.

Source files
------------

// File: rtl/row_mem_rd_ctrlr.sv
// Read-sweep sequencer for IA/weight row memories: walks oc -> x -> kx and issues
// one registered broadcast read per accepted cycle, flagging returned data one cycle later.
module row_mem_rd_ctrlr #(
  parameter int INPUT_BW            = 8,
  parameter int IA_ROW_MEM_ADDR     = 6,
  parameter int WEIGHT_ROW_MEM_ADDR = 7,
  parameter int NUM_IA_ROW_MEM      = 96,
  parameter int NUM_WEIGHT_ROW_MEM  = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  output logic                           done,
  output logic                           cfg_err,
  input  logic [5:0]                     OC,
  input  logic [5:0]                     IMG_W,
  input  logic [2:0]                     K,
  input  logic [NUM_IA_ROW_MEM-1:0]      which_ia_row_mem_activate,
  input  logic                           pe_ready,
  output logic [NUM_IA_ROW_MEM-1:0]      ia_rd_en,
  output logic [IA_ROW_MEM_ADDR-1:0]     ia_rd_addr,
  output logic [NUM_WEIGHT_ROW_MEM-1:0]  weight_rd_en,
  output logic [WEIGHT_ROW_MEM_ADDR-1:0] weight_rd_addr,
  output logic                           rd_valid,
  output logic                           kx_last,
  output logic                           rd_last,
  output logic [1:0]                     dbg_state
);

  // Address arithmetic runs at 8 bits, or the entry width if that is ever wider.
  localparam int ADDR_W = (INPUT_BW > 8) ? INPUT_BW : 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                           state_q, state_d;
  logic [5:0]                       oc_cfg_q, oc_cfg_d, w_cfg_q, w_cfg_d;
  logic [2:0]                       k_cfg_q, k_cfg_d;
  logic [NUM_IA_ROW_MEM-1:0]        mask_q, mask_d;
  logic [5:0]                       oc_q, oc_d, x_q, x_d;
  logic [2:0]                       kx_q, kx_d;
  logic [NUM_IA_ROW_MEM-1:0]        ia_rd_en_q, ia_rd_en_d;
  logic [IA_ROW_MEM_ADDR-1:0]       ia_rd_addr_q, ia_rd_addr_d;
  logic [NUM_WEIGHT_ROW_MEM-1:0]    weight_rd_en_q, weight_rd_en_d;
  logic [WEIGHT_ROW_MEM_ADDR-1:0]   weight_rd_addr_q, weight_rd_addr_d;
  logic                             kx_last_p_q, kx_last_p_d, rd_last_p_q, rd_last_p_d;
  logic                             rd_valid_q, rd_valid_d, kx_last_q, kx_last_d, rd_last_q, rd_last_d;
  logic                             done_q, done_d, cfg_err_q, cfg_err_d;

  logic [8:0]                       oc_k;
  logic [6:0]                       span;
  logic                             cfg_ok;
  logic                             is_kx_last, is_x_last, is_oc_last;
  logic [ADDR_W-1:0]                ia_addr_full, w_addr_full;
  logic [NUM_WEIGHT_ROW_MEM-1:0]    w_en_mask;

  assign oc_k   = 9'(OC) * 9'(K);
  assign span   = 7'(IMG_W) + 7'(K) - 7'd1;
  assign cfg_ok = (K >= 3'd1) && (K <= 3'd3) && (OC != 6'd0) && (IMG_W != 6'd0) &&
                  (span <= 7'd64) && (oc_k <= 9'd128);

  assign is_kx_last   = (kx_q == k_cfg_q - 3'd1);
  assign is_x_last    = (x_q == w_cfg_q - 6'd1);
  assign is_oc_last   = (oc_q == oc_cfg_q - 6'd1);
  assign ia_addr_full = ADDR_W'(x_q) + ADDR_W'(kx_q);
  assign w_addr_full  = ADDR_W'(oc_q) * ADDR_W'(k_cfg_q) + ADDR_W'(kx_q);

  always_comb begin
    w_en_mask = '0;
    for (int i = 0; i < NUM_WEIGHT_ROW_MEM; i++) w_en_mask[i] = (i < int'(k_cfg_q));
  end

  // Handshake: pe_ready is the ready half of a valid/ready pair whose valid is
  // "FSM in READ". A read transfers on a rising edge only when both hold; on any
  // other edge all rd_en go low and the oc/x/kx counters keep their value.
  always_comb begin
    state_d          = state_q;
    oc_cfg_d         = oc_cfg_q;
    w_cfg_d          = w_cfg_q;
    k_cfg_d          = k_cfg_q;
    mask_d           = mask_q;
    oc_d             = oc_q;
    x_d              = x_q;
    kx_d             = kx_q;
    ia_rd_en_d       = '0;
    ia_rd_addr_d     = ia_rd_addr_q;
    weight_rd_en_d   = '0;
    weight_rd_addr_d = weight_rd_addr_q;
    kx_last_p_d      = 1'b0;
    rd_last_p_d      = 1'b0;
    rd_valid_d       = (|ia_rd_en_q) || (|weight_rd_en_q);
    kx_last_d        = kx_last_p_q;
    rd_last_d        = rd_last_p_q;
    done_d           = 1'b0;
    cfg_err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          oc_cfg_d = OC;
          w_cfg_d  = IMG_W;
          k_cfg_d  = K;
          mask_d   = which_ia_row_mem_activate;
          oc_d     = '0;
          x_d      = '0;
          kx_d     = '0;
          if (cfg_ok) begin
            state_d = S_READ;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (pe_ready) begin
          ia_rd_en_d       = mask_q;
          ia_rd_addr_d     = IA_ROW_MEM_ADDR'(ia_addr_full);
          weight_rd_en_d   = w_en_mask;
          weight_rd_addr_d = WEIGHT_ROW_MEM_ADDR'(w_addr_full);
          kx_last_p_d      = is_kx_last;
          rd_last_p_d      = is_kx_last && is_x_last && is_oc_last;
          if (!is_kx_last) begin
            kx_d = kx_q + 3'd1;
          end else begin
            kx_d = '0;
            if (!is_x_last) begin
              x_d = x_q + 6'd1;
            end else begin
              x_d = '0;
              if (!is_oc_last) begin
                oc_d = oc_q + 6'd1;
              end else begin
                oc_d    = '0;
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: begin
        // An illegal config already pulsed done while entering DONE; only a real sweep pulses here.
        state_d = S_IDLE;
        done_d  = !cfg_err_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      oc_cfg_q         <= '0;
      w_cfg_q          <= '0;
      k_cfg_q          <= '0;
      mask_q           <= '0;
      oc_q             <= '0;
      x_q              <= '0;
      kx_q             <= '0;
      ia_rd_en_q       <= '0;
      ia_rd_addr_q     <= '0;
      weight_rd_en_q   <= '0;
      weight_rd_addr_q <= '0;
      kx_last_p_q      <= 1'b0;
      rd_last_p_q      <= 1'b0;
      rd_valid_q       <= 1'b0;
      kx_last_q        <= 1'b0;
      rd_last_q        <= 1'b0;
      done_q           <= 1'b0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      oc_cfg_q         <= oc_cfg_d;
      w_cfg_q          <= w_cfg_d;
      k_cfg_q          <= k_cfg_d;
      mask_q           <= mask_d;
      oc_q             <= oc_d;
      x_q              <= x_d;
      kx_q             <= kx_d;
      ia_rd_en_q       <= ia_rd_en_d;
      ia_rd_addr_q     <= ia_rd_addr_d;
      weight_rd_en_q   <= weight_rd_en_d;
      weight_rd_addr_q <= weight_rd_addr_d;
      kx_last_p_q      <= kx_last_p_d;
      rd_last_p_q      <= rd_last_p_d;
      rd_valid_q       <= rd_valid_d;
      kx_last_q        <= kx_last_d;
      rd_last_q        <= rd_last_d;
      done_q           <= done_d;
      cfg_err_q        <= cfg_err_d;
    end
  end

  assign done           = done_q;
  assign cfg_err        = cfg_err_q;
  assign ia_rd_en       = ia_rd_en_q;
  assign ia_rd_addr     = ia_rd_addr_q;
  assign weight_rd_en   = weight_rd_en_q;
  assign weight_rd_addr = weight_rd_addr_q;
  assign rd_valid       = rd_valid_q;
  assign kx_last        = kx_last_q;
  assign rd_last        = rd_last_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_row_mem_rd_ctrlr.sv
// Bench for row_mem_rd_ctrlr: table of configurations plus random sweeps, each checked
// cycle by cycle against a model that lists the expected reads with nested loops.
module tb_row_mem_rd_ctrlr;
  localparam int NIA = 96;
  localparam int NW  = 3;
  localparam int IAW = 6;
  localparam int WW  = 7;

  logic             clk = 1'b0;
  logic             resetn, start, pe_ready;
  logic [5:0]       oc_in, imgw_in;
  logic [2:0]       k_in;
  logic [NIA-1:0]   mask_in;
  logic             done, cfg_err, rd_valid, kx_last, rd_last;
  logic [NIA-1:0]   ia_rd_en;
  logic [IAW-1:0]   ia_rd_addr;
  logic [NW-1:0]    weight_rd_en;
  logic [WW-1:0]    weight_rd_addr;
  logic [1:0]       dbg_state;

  row_mem_rd_ctrlr dut (
    .clk(clk), .resetn(resetn), .start(start), .done(done), .cfg_err(cfg_err),
    .OC(oc_in), .IMG_W(imgw_in), .K(k_in), .which_ia_row_mem_activate(mask_in),
    .pe_ready(pe_ready), .ia_rd_en(ia_rd_en), .ia_rd_addr(ia_rd_addr),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
    .rd_valid(rd_valid), .kx_last(kx_last), .rd_last(rd_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_rd;
  int obs_ia[$];
  int obs_w[$];

  typedef struct {
    logic [5:0] oc;
    logic [5:0] w;
    logic [2:0] k;
    int         stall;
    logic       exp_err;
    int         exp_reads;
  } vec_t;

  vec_t tbl[11];
  int   lit_ia[3][6];
  int   lit_w[3][6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".cfg_err"}, cfg_err, 0);
    chk({tag, ".ia_rd_en"}, ia_rd_en, 0);
    chk({tag, ".ia_rd_addr"}, ia_rd_addr, 0);
    chk({tag, ".weight_rd_en"}, weight_rd_en, 0);
    chk({tag, ".weight_rd_addr"}, weight_rd_addr, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".kx_last"}, kx_last, 0);
    chk({tag, ".rd_last"}, rd_last, 0);
    chk({tag, ".dbg_state"}, dbg_state, 0);
  endtask

  // driver + scoreboard for one sweep; stall 0=always ready, 1=ready on odd edges, 2=random
  task automatic run_sweep(input logic [5:0] oc, input logic [5:0] w, input logic [2:0] k,
                           input logic [NIA-1:0] mask, input int stall, input bit scramble);
    int ia_q[$], wa_q[$];
    bit kl_q[$], ll_q[$];
    bit legal, rdy, issue, pv, pkl, pll, have;
    int total, idx, last_j, j, h_ia, h_w;
    logic [NW-1:0] wmask;
    legal = (k >= 1) && (k <= 3) && (oc != 0) && (w != 0) &&
            (int'(w) + int'(k) - 1 <= 64) && (int'(oc) * int'(k) <= 128);
    if (legal)
      for (int o = 0; o < int'(oc); o++)
        for (int xx = 0; xx < int'(w); xx++)
          for (int kk = 0; kk < int'(k); kk++) begin
            ia_q.push_back(xx + kk);
            wa_q.push_back(o * int'(k) + kk);
            kl_q.push_back(kk == int'(k) - 1);
            ll_q.push_back((o == int'(oc) - 1) && (xx == int'(w) - 1) && (kk == int'(k) - 1));
          end
    total = ia_q.size();
    wmask = '0;
    for (int i = 0; i < NW; i++) wmask[i] = (i < int'(k));
    obs_ia.delete();
    obs_w.delete();
    n_rd = 0;
    oc_in = oc; imgw_in = w; k_in = k; mask_in = mask;
    start = 1'b1;
    pe_ready = 1'($urandom_range(0, 1));
    idx = 0; last_j = -1; pv = 0; pkl = 0; pll = 0; have = 0; h_ia = 0; h_w = 0; j = 0;
    while (1) begin
      if (j > 0) begin
        if (stall == 0) rdy = 1;
        else if (stall == 1) rdy = (j % 2 == 1);
        else rdy = ($urandom_range(0, 3) != 0);
        pe_ready = rdy;
      end else begin
        rdy = 0;
      end
      step();
      issue = legal && (j >= 1) && rdy && (idx < total);
      chk("ia_rd_en", ia_rd_en, issue ? mask : '0);
      chk("weight_rd_en", weight_rd_en, issue ? wmask : 3'b0);
      if (issue) begin
        h_ia = ia_q[idx];
        h_w  = wa_q[idx];
        have = 1;
      end
      if (have) begin
        chk("ia_rd_addr", ia_rd_addr, h_ia);
        chk("weight_rd_addr", weight_rd_addr, h_w);
      end
      chk("rd_valid", rd_valid, pv);
      chk("kx_last", kx_last, pkl);
      chk("rd_last", rd_last, pll);
      chk("done", done, legal ? (last_j >= 0 && j == last_j + 2) : (j == 0));
      chk("cfg_err", cfg_err, !legal && j == 0);
      if (ia_rd_en != '0 || weight_rd_en != '0) begin
        n_rd++;
        obs_ia.push_back(int'(ia_rd_addr));
        obs_w.push_back(int'(weight_rd_addr));
      end
      pv  = issue;
      pkl = issue && kl_q[idx];
      pll = issue && ll_q[idx];
      if (issue) begin
        idx++;
        if (idx == total) last_j = j;
      end
      start = 1'b0;
      if (scramble && legal && idx < total) begin
        start   = 1'($urandom_range(0, 1));
        oc_in   = 6'($urandom);
        imgw_in = 6'($urandom);
        k_in    = 3'($urandom);
        mask_in = {$urandom, $urandom, $urandom};
      end
      if (legal ? (last_j >= 0 && j == last_j + 3) : (j == 3)) break;
      j++;
    end
    start = 1'b0;
    pe_ready = 1'b0;
  endtask

  task automatic chk_lit(input int row, input int len);
    chk("seq_len", obs_ia.size(), len);
    if (obs_ia.size() == len)
      for (int i = 0; i < len; i++) begin
        chk($sformatf("seq%0d_ia[%0d]", row, i), obs_ia[i], lit_ia[row][i]);
        chk($sformatf("seq%0d_w[%0d]", row, i), obs_w[i], lit_w[row][i]);
      end
  endtask

  initial begin
    tbl[0]  = '{6'd1,  6'd2,  3'd3, 0, 1'b0, 6};
    tbl[1]  = '{6'd2,  6'd3,  3'd1, 0, 1'b0, 6};
    tbl[2]  = '{6'd1,  6'd2,  3'd2, 1, 1'b0, 4};
    tbl[3]  = '{6'd1,  6'd2,  3'd4, 0, 1'b1, 0};
    tbl[4]  = '{6'd0,  6'd5,  3'd2, 0, 1'b1, 0};
    tbl[5]  = '{6'd1,  6'd63, 3'd3, 0, 1'b1, 0};
    tbl[6]  = '{6'd1,  6'd62, 3'd3, 1, 1'b0, 186};
    tbl[7]  = '{6'd43, 6'd1,  3'd3, 0, 1'b1, 0};
    tbl[8]  = '{6'd42, 6'd1,  3'd3, 2, 1'b0, 126};
    tbl[9]  = '{6'd2,  6'd2,  3'd0, 0, 1'b1, 0};
    tbl[10] = '{6'd2,  6'd0,  3'd1, 0, 1'b1, 0};
    lit_ia[0] = '{0, 1, 2, 1, 2, 3};  lit_w[0] = '{0, 1, 2, 0, 1, 2};
    lit_ia[1] = '{0, 1, 2, 0, 1, 2};  lit_w[1] = '{0, 0, 0, 1, 1, 1};
    lit_ia[2] = '{0, 1, 1, 2, 0, 0};  lit_w[2] = '{0, 1, 0, 1, 0, 0};

    resetn = 1'b0; start = 1'b0; pe_ready = 1'b0;
    oc_in = '0; imgw_in = '0; k_in = '0; mask_in = '0;
    repeat (3) step();
    chk_all_zero("reset");
    resetn = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    for (int t = 0; t < 11; t++) begin
      run_sweep(tbl[t].oc, tbl[t].w, tbl[t].k, {$urandom, $urandom, $urandom}, tbl[t].stall, 1'b1);
      chk($sformatf("tbl%0d_reads", t), n_rd, tbl[t].exp_reads);
      if (t < 3) chk_lit(t, tbl[t].exp_reads);
    end

    // reset asserted for one edge right after the third read of a sweep
    oc_in = 6'd1; imgw_in = 6'd2; k_in = 3'd3; mask_in = {32'h0, 32'h0, 32'hA5A5_0F0F};
    pe_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("mid_rst_rd3_ia_addr", ia_rd_addr, 2);
    chk("mid_rst_rd3_w_addr", weight_rd_addr, 2);
    resetn = 1'b0;
    step();
    chk_all_zero("mid_rst");
    resetn = 1'b1;
    repeat (6) begin
      step();
      chk("mid_rst_no_done", done, 0);
      chk("mid_rst_no_rd", ia_rd_en, '0);
    end
    run_sweep(6'd1, 6'd2, 3'd3, {32'h0, 32'h0, 32'hA5A5_0F0F}, 0, 1'b0);
    chk_lit(0, 6);

    for (int r = 0; r < 20; r++) begin
      run_sweep(6'($urandom_range(0, 8)), 6'($urandom_range(0, 9)), 3'($urandom_range(0, 4)),
                {$urandom, $urandom, $urandom}, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
